// File: rtl/preemph_pkg.sv
// Shared definitions for the pre-emphasis FIR: accumulator sizing, output
// saturation and the saturation-counter width.
package preemph_pkg;

  localparam int SAT_CNT_W  = 16;
  localparam int SAT_CALC_W = 64;

  typedef struct packed {
    logic        clamped;
    logic [SAT_CALC_W-1:0] value;
  } sat_t;

  // Full-precision partial-sum width: every product plus log2(NTAPS) growth bits.
  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Clamps a sign-extended value into the signed range of data_w bits.
  function automatic sat_t saturate(input logic signed [SAT_CALC_W-1:0] v,
                                    input int data_w);
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.clamped = 1'b0;
    r.value   = v;
    if (v > hi) begin
      r.clamped = 1'b1;
      r.value   = hi;
    end else if (v < lo) begin
      r.clamped = 1'b1;
      r.value   = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/preemph_fir_if.sv
// Sample stream into and out of the pre-emphasis FIR.
// Valid-only handshake: in_valid qualifies in_data and advances the pipeline on
// that edge (no ready, every valid sample is accepted); out_valid qualifies
// out_data, which holds its last value while out_valid is low.
interface preemph_fir_if #(
  parameter int DATA_W = 8
);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/preemph_tap.sv
// One transposed-form tap: product of the current sample and this tap's
// coefficient added to the downstream partial sum, registered when enabled.
module preemph_tap #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4,
  parameter int ACC_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  input  logic signed [ACC_W-1:0]  sum_in,
  output logic signed [ACC_W-1:0]  sum_out
);

  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0] prod;

  assign prod = PW'(x) * PW'(c);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sum_out <= '0;
    end else if (en) begin
      sum_out <= ACC_W'(prod) + sum_in;
    end
  end

endmodule

// File: rtl/preemph_fir.sv
// Transposed-form pre-emphasis FIR with double-buffered coefficients, output
// shift and saturation, and a sticky saturation-event counter.
module preemph_fir
  import preemph_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  COEF_W = 4,
  parameter int  NTAPS  = 4,
  parameter int  SHIFT  = 0,
  localparam int ADDR_W = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_commit,
  input  logic                     flush,
  input  logic                     sat_clr,
  output logic [SAT_CNT_W-1:0]     sat_cnt,
  preemph_fir_if.slave             strm
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int PW    = DATA_W + COEF_W;

  logic signed [COEF_W-1:0] shadow     [NTAPS];
  logic signed [COEF_W-1:0] shadow_nxt [NTAPS];
  logic signed [COEF_W-1:0] active     [NTAPS];
  logic                     addr_ok;

  // Address range check only matters when NTAPS is not a power of two.
  if ((1 << ADDR_W) == NTAPS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = ({1'b0, coef_addr} < (ADDR_W + 1)'(NTAPS));
  end

  // The shadow bank including this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      shadow_nxt[i] = shadow[i];
    end
    if (coef_we && addr_ok) begin
      shadow_nxt[coef_addr] = coef_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= (i == 0) ? COEF_W'(1) : '0;
        active[i] <= (i == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= shadow_nxt[i];
      end
      if (coef_commit) begin
        for (int i = 0; i < NTAPS; i++) begin
          active[i] <= shadow_nxt[i];
        end
      end
    end
  end

  // psum[i] is the registered partial sum leaving tap i; psum[0] is the
  // combinational full sum, psum[NTAPS] the constant zero feeding the last tap.
  logic signed [ACC_W-1:0] psum [NTAPS+1];
  logic signed [PW-1:0]    prod0;
  logic signed [ACC_W-1:0] shifted;
  sat_t                    sat_r;
  logic                    sat_evt;

  assign psum[NTAPS] = '0;

  for (genvar i = 1; i < NTAPS; i++) begin : g_tap
    preemph_tap #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_tap (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (strm.in_valid),
      .clr     (flush),
      .x       (strm.in_data),
      .c       (active[i]),
      .sum_in  (psum[i+1]),
      .sum_out (psum[i])
    );
  end

  assign prod0   = PW'(strm.in_data) * PW'(active[0]);
  assign psum[0] = ACC_W'(prod0) + psum[1];
  assign shifted = psum[0] >>> SHIFT;
  assign sat_r   = saturate(SAT_CALC_W'(shifted), DATA_W);
  assign sat_evt = strm.in_valid && !flush && sat_r.clamped;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
    end else begin
      strm.out_valid <= strm.in_valid;
      if (strm.in_valid) begin
        strm.out_data <= DATA_W'(sat_r.value);
      end
    end
  end

  // sat_clr outranks a coincident event; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || sat_clr) begin
      sat_cnt <= '0;
    end else if (sat_evt && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + SAT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_preemph_fir.sv
// Directed bench for preemph_fir (DATA_W=8, COEF_W=4, NTAPS=4, SHIFT=0) using
// hand-computed per-cycle vectors for outputs and the saturation counter.
module tb_preemph_fir;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [3:0]  coef_wdata;
  logic               coef_commit;
  logic               flush;
  logic               sat_clr;
  logic [15:0]        sat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  preemph_fir_if #(.DATA_W(8)) bus ();

  preemph_fir #(
    .DATA_W (8),
    .COEF_W (4),
    .NTAPS  (4),
    .SHIFT  (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit),
    .flush       (flush),
    .sat_clr     (sat_clr),
    .sat_cnt     (sat_cnt),
    .strm        (bus)
  );

  typedef struct {
    logic              rst_n;
    logic              flush;
    logic              sat_clr;
    logic              we;
    logic [1:0]        addr;
    logic signed [3:0] wd;
    logic              commit;
    logic              iv;
    logic signed [7:0] id;
    logic              ev;
    int                ed;
    int                es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic fl, logic sc, logic we, int addr, int wd,
                              logic cm, logic iv, int id, logic ev, int ed, int es);
    vec_t v;
    v.rst_n   = r;
    v.flush   = fl;
    v.sat_clr = sc;
    v.we      = we;
    v.addr    = 2'(addr);
    v.wd      = 4'(wd);
    v.commit  = cm;
    v.iv      = iv;
    v.id      = 8'(id);
    v.ev      = ev;
    v.ed      = ed;
    v.es      = es;
    return v;
  endfunction

  // Plain sample cycle.
  function automatic vec_t smp(logic iv, int id, logic ev, int ed, int es);
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, iv, id, ev, ed, es);
  endfunction

  // Idle coefficient write, optionally committing in the same cycle.
  function automatic vec_t cw(int addr, int wd, logic cm, int ed, int es);
    return mk(1'b1, 1'b0, 1'b0, 1'b1, addr, wd, cm, 1'b0, 0, 1'b0, ed, es);
  endfunction

  task automatic check(string name, int row, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0d expected=%0d", name, row, got, exp);
    end
  endtask

  task automatic run_row(vec_t v, int row);
    rst_n         = v.rst_n;
    flush         = v.flush;
    sat_clr       = v.sat_clr;
    coef_we       = v.we;
    coef_addr     = v.addr;
    coef_wdata    = v.wd;
    coef_commit   = v.commit;
    bus.in_valid  = v.iv;
    bus.in_data   = v.id;
    @(posedge clk);
    #1;
    check("out_valid", row, int'(bus.out_valid), int'(v.ev));
    check("out_data",  row, int'(bus.out_data),  v.ed);
    check("sat_cnt",   row, int'(sat_cnt),       v.es);
  endtask

  initial begin
    // Reset with a valid sample present: everything stays cleared.
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 33, 1'b0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 33, 1'b0, 0, 0));
    // Pass-through bank after reset.
    tbl.push_back(smp(1'b1, 5, 1'b1, 5, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(smp(1'b1, 0, 1'b1, 0, 0));
    tbl.push_back(smp(1'b0, 0, 1'b0, 0, 0));
    // Bank {1,-1,0,0}, commit coincides with the last write.
    tbl.push_back(cw(0,  1, 1'b0, 0, 0));
    tbl.push_back(cw(1, -1, 1'b0, 0, 0));
    tbl.push_back(cw(2,  0, 1'b0, 0, 0));
    tbl.push_back(cw(3,  0, 1'b1, 0, 0));
    tbl.push_back(smp(1'b1, 10, 1'b1,  10, 0));
    tbl.push_back(smp(1'b1,  0, 1'b1, -10, 0));
    tbl.push_back(smp(1'b1,  0, 1'b1,   0, 0));
    tbl.push_back(smp(1'b1,  0, 1'b1,   0, 0));
    // Valid gap: state and out_data hold, result matches the gapless 3,7,0.
    tbl.push_back(smp(1'b1,  3, 1'b1,  3, 0));
    tbl.push_back(smp(1'b0, 99, 1'b0,  3, 0));
    tbl.push_back(smp(1'b1,  7, 1'b1,  4, 0));
    tbl.push_back(smp(1'b1,  0, 1'b1, -7, 0));
    // Bank {7,7,7,7} with full-scale input saturates every output.
    for (int a = 0; a < 4; a++) tbl.push_back(cw(a, 7, (a == 3), -7, 0));
    for (int k = 1; k <= 4; k++) tbl.push_back(smp(1'b1, 127, 1'b1, 127, k));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 127, 1'b1, 127, 0));
    tbl.push_back(smp(1'b1, 127, 1'b1, 127, 1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 5, 1'b0, 0, 1));
    tbl.push_back(smp(1'b1, -128, 1'b1, -128, 2));
    tbl.push_back(smp(1'b1, -128, 1'b1, -128, 3));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 3));
    // Bank {1,1,1,1}, then rebuild to {2,0,0,-1} while streaming.
    for (int a = 0; a < 4; a++) tbl.push_back(cw(a, 1, (a == 3), 0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1,  0, 1'b0, 1'b1, 1, 1'b1,  1, 3));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2,  0, 1'b0, 1'b1, 2, 1'b1,  3, 3));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 3, -1, 1'b0, 1'b1, 3, 1'b1,  6, 3));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 0,  2, 1'b1, 1'b1, 4, 1'b1, 10, 3));
    tbl.push_back(smp(1'b1, 5, 1'b1, 19, 3));
    tbl.push_back(smp(1'b1, 0, 1'b1,  7, 3));
    tbl.push_back(smp(1'b1, 0, 1'b1,  4, 3));
    tbl.push_back(smp(1'b1, 0, 1'b1, -5, 3));
    tbl.push_back(smp(1'b1, 0, 1'b1,  0, 3));
    // Flush mid-stream clears the delay line.
    tbl.push_back(smp(1'b1, 10, 1'b1, 20, 3));
    tbl.push_back(smp(1'b1, 10, 1'b1, 20, 3));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 50, 1'b0, 0, 3));
    for (int i = 0; i < 3; i++) tbl.push_back(smp(1'b1, 0, 1'b1, 0, 3));

    for (int i = 0; i < tbl.size(); i++) begin
      run_row(tbl[i], i);
    end

    // Reset mid-stream: in-flight sample discarded, bank back to pass-through.
    run_row(smp(1'b1, 10, 1'b1, 20, 3), 1000);
    run_row(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 10, 1'b0, 0, 0), 1001);
    for (int i = 0; i < 3; i++) run_row(smp(1'b1, 0, 1'b1, 0, 0), 1002 + i);
    run_row(smp(1'b1, 9, 1'b1, 9, 0), 1005);
    run_row(smp(1'b1, 0, 1'b1, 0, 0), 1006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
